// File: rtl/ace_snoop_pkg.sv
// Shared types and helpers for the ACE snoop unit.
//   snoop_op_e     : operation requested from the cache for one snoop
//   Cr*            : bit positions inside CRRESP
//   Ac*            : ACSNOOP opcodes handled by the unit
//   decode_snoop() : ACSNOOP -> {cache op, supported}
//   snoop_resp()   : ACSNOOP + line state -> CRRESP
package ace_snoop_pkg;

  typedef enum logic [1:0] {
    OpRead       = 2'd0,
    OpMakeShared = 2'd1,
    OpInvalidate = 2'd2
  } snoop_op_e;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  localparam logic [3:0] AcReadOnce           = 4'b0000;
  localparam logic [3:0] AcReadShared         = 4'b0001;
  localparam logic [3:0] AcReadClean          = 4'b0010;
  localparam logic [3:0] AcReadNotSharedDirty = 4'b0011;
  localparam logic [3:0] AcReadUnique         = 4'b0111;
  localparam logic [3:0] AcCleanShared        = 4'b1000;
  localparam logic [3:0] AcCleanInvalid       = 4'b1001;
  localparam logic [3:0] AcMakeInvalid        = 4'b1101;

  typedef struct packed {
    snoop_op_e op;
    logic      supported;
  } snoop_dec_t;

  function automatic snoop_dec_t decode_snoop(input logic [3:0] snoop);
    snoop_dec_t dec;
    dec.op        = OpRead;
    dec.supported = 1'b1;
    case (snoop)
      AcReadOnce:                     dec.op = OpRead;
      AcReadShared, AcReadClean,
      AcReadNotSharedDirty,
      AcCleanShared:                  dec.op = OpMakeShared;
      AcReadUnique, AcCleanInvalid,
      AcMakeInvalid:                  dec.op = OpInvalidate;
      default:                        dec.supported = 1'b0;
    endcase
    return dec;
  endfunction

  // A miss answers all-zero regardless of opcode; Error is never raised.
  function automatic logic [4:0] snoop_resp(input logic [3:0] snoop, input logic hit,
                                            input logic dirty, input logic shared);
    logic [4:0] resp;
    resp = '0;
    if (hit) begin
      resp[CrWasUnique] = ~shared;
      case (snoop)
        AcReadOnce: begin
          resp[CrDataTransfer] = 1'b1;
          resp[CrIsShared]     = 1'b1;
        end
        AcReadShared, AcReadClean, AcReadNotSharedDirty: begin
          resp[CrDataTransfer] = 1'b1;
          resp[CrIsShared]     = 1'b1;
          resp[CrPassDirty]    = dirty;
        end
        AcReadUnique, AcCleanInvalid: begin
          resp[CrDataTransfer] = 1'b1;
          resp[CrPassDirty]    = dirty;
        end
        AcCleanShared: begin
          resp[CrDataTransfer] = dirty;
          resp[CrIsShared]     = 1'b1;
          resp[CrPassDirty]    = dirty;
        end
        AcMakeInvalid: ;
        default:       resp = '0;
      endcase
    end
    return resp;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO (common_cells-style fifo_v3, active-high async reset variant).
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : synchronous clear
//   full_o, empty_o   : status; with FALL_THROUGH empty_o also drops on a push into an empty FIFO
//   data_i, push_i    : write side
//   data_o, pop_i     : read side
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

  logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
  logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
  logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  bypass;
  logic                  do_write;

  // Push straight through to a same-cycle pop when nothing is stored.
  assign bypass   = FALL_THROUGH && (status_cnt_q == '0) && push_i && pop_i;
  assign full_o   = (status_cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o  = (status_cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign do_write = push_i && !full_o && !bypass;

  always_comb begin
    read_ptr_d   = read_ptr_q;
    write_ptr_d  = write_ptr_q;
    status_cnt_d = status_cnt_q;
    data_o       = mem_q[read_ptr_q];
    if (FALL_THROUGH && (status_cnt_q == '0) && push_i) data_o = data_i;

    if (do_write) begin
      write_ptr_d  = (write_ptr_q == LastPtr) ? '0 : write_ptr_q + 1'b1;
      status_cnt_d = status_cnt_d + 1'b1;
    end
    if (pop_i && !empty_o && !bypass) begin
      read_ptr_d   = (read_ptr_q == LastPtr) ? '0 : read_ptr_q + 1'b1;
      status_cnt_d = status_cnt_d - 1'b1;
    end
    if (flush_i) begin
      read_ptr_d   = '0;
      write_ptr_d  = '0;
      status_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else begin
      read_ptr_q   <= read_ptr_d;
      write_ptr_q  <= write_ptr_d;
      status_cnt_q <= status_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write && !flush_i) mem_q[write_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ace_snoop_unit.sv
// ACE snoop-channel slave for the data cache.
// Buffers AC requests, performs one cache lookup per snoop, answers on CR and streams
// the line on CD (lowest beat first) when DataTransfer is set.
//   clk_i, rst_i                     : clock, asynchronous active-high reset
//   ac_*                             : AC snoop request channel (ac_prot_i is carried but unused)
//   cr_*                             : CR snoop response channel
//   cd_*                             : CD snoop data channel
//   cache_req_o/gnt_i/addr_o/op_o    : lookup request handshake
//   cache_rvalid_i/hit/dirty/shared/line : lookup result (state before the op is applied)
//   busy_o                           : work pending or in flight
module ace_snoop_unit
  import ace_snoop_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned LineWidth   = 128,
  parameter int unsigned AcFifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 cache_req_o,
  input  logic                 cache_gnt_i,
  output logic [AddrWidth-1:0] cache_addr_o,
  output logic [1:0]           cache_op_o,
  input  logic                 cache_rvalid_i,
  input  logic                 cache_hit_i,
  input  logic                 cache_dirty_i,
  input  logic                 cache_shared_i,
  input  logic [LineWidth-1:0] cache_line_i,
  output logic                 busy_o
);

  localparam int unsigned Beats       = LineWidth / DataWidth;
  localparam int unsigned BeatWidth   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffsetWidth = $clog2(LineWidth / 8);
  localparam int unsigned AcWidth     = AddrWidth + 4 + 3;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWaitR, StSendCr, StSendCd} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  snoop_op_e              op_q, op_d;
  logic [4:0]             resp_q, resp_d;
  logic [LineWidth-1:0]   line_q, line_d;
  logic [BeatWidth-1:0]   beat_q, beat_d;

  logic                   ac_full, ac_empty, ac_pop;
  logic [AcWidth-1:0]     ac_rdata;
  logic [AddrWidth-1:0]   fifo_addr;
  logic [3:0]             fifo_snoop;
  snoop_dec_t             dec;

  // Fall-through so an AC accepted into an empty, idle unit is looked up the next cycle.
  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   (AcWidth),
    .DEPTH        (AcFifoDepth)
  ) u_ac_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .full_o  (ac_full),
    .empty_o (ac_empty),
    .data_i  ({ac_addr_i, ac_snoop_i, ac_prot_i}),
    .push_i  (ac_valid_i & ~ac_full),
    .data_o  (ac_rdata),
    .pop_i   (ac_pop)
  );

  assign ac_ready_o = ~ac_full;
  assign fifo_addr  = ac_rdata[AcWidth-1 -: AddrWidth];
  assign fifo_snoop = ac_rdata[6:3];
  assign dec        = decode_snoop(fifo_snoop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    op_d        = op_q;
    resp_d      = resp_q;
    line_d      = line_q;
    beat_d      = beat_q;
    ac_pop      = 1'b0;
    cache_req_o = 1'b0;
    cr_valid_o  = 1'b0;
    cd_valid_o  = 1'b0;
    cd_last_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!ac_empty) begin
          ac_pop  = 1'b1;
          addr_d  = {fifo_addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
          snoop_d = fifo_snoop;
          op_d    = dec.op;
          if (dec.supported) begin
            state_d = StReq;
          end else begin
            resp_d  = '0;
            state_d = StSendCr;
          end
        end
      end
      StReq: begin
        cache_req_o = 1'b1;
        if (cache_gnt_i) state_d = StWaitR;
      end
      StWaitR: begin
        if (cache_rvalid_i) begin
          resp_d  = snoop_resp(snoop_q, cache_hit_i, cache_dirty_i, cache_shared_i);
          line_d  = cache_line_i;
          state_d = StSendCr;
        end
      end
      StSendCr: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          beat_d  = '0;
          state_d = resp_q[CrDataTransfer] ? StSendCd : StIdle;
        end
      end
      StSendCd: begin
        cd_valid_o = 1'b1;
        cd_last_o  = (beat_q == LastBeat);
        if (cd_ready_i) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      snoop_q <= '0;
      op_q    <= OpRead;
      resp_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      op_q    <= op_d;
      resp_q  <= resp_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
    end
  end

  assign cr_resp_o    = resp_q;
  assign cd_data_o    = line_q[int'(beat_q) * DataWidth +: DataWidth];
  assign cache_addr_o = addr_q;
  assign cache_op_o   = op_q;
  assign busy_o       = (state_q != StIdle) | ~ac_empty;

endmodule

// File: tb/tb_ace_snoop_unit.sv
// Directed bench for ace_snoop_unit with a one-line cache responder model.
module tb_ace_snoop_unit;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         ac_valid_i, ac_ready_o;
  logic [63:0]  ac_addr_i;
  logic [3:0]   ac_snoop_i;
  logic [2:0]   ac_prot_i;
  logic         cr_valid_o, cr_ready_i;
  logic [4:0]   cr_resp_o;
  logic         cd_valid_o, cd_ready_i, cd_last_o;
  logic [63:0]  cd_data_o;
  logic         cache_req_o, cache_gnt_i;
  logic [63:0]  cache_addr_o;
  logic [1:0]   cache_op_o;
  logic         cache_rvalid_i, cache_hit_i, cache_dirty_i, cache_shared_i;
  logic [127:0] cache_line_i;
  logic         busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // responder / monitor state
  bit          pend = 1'b0;
  int          lookups = 0;
  int          req_cycles = 0;
  int          rv_cyc = -10;
  bit          cd_seen = 1'b0;
  logic [63:0] look_addr[$];

  ace_snoop_unit #(
    .AddrWidth   (64),
    .DataWidth   (64),
    .LineWidth   (128),
    .AcFifoDepth (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ac_valid_i     (ac_valid_i),
    .ac_ready_o     (ac_ready_o),
    .ac_addr_i      (ac_addr_i),
    .ac_snoop_i     (ac_snoop_i),
    .ac_prot_i      (ac_prot_i),
    .cr_valid_o     (cr_valid_o),
    .cr_ready_i     (cr_ready_i),
    .cr_resp_o      (cr_resp_o),
    .cd_valid_o     (cd_valid_o),
    .cd_ready_i     (cd_ready_i),
    .cd_data_o      (cd_data_o),
    .cd_last_o      (cd_last_o),
    .cache_req_o    (cache_req_o),
    .cache_gnt_i    (cache_gnt_i),
    .cache_addr_o   (cache_addr_o),
    .cache_op_o     (cache_op_o),
    .cache_rvalid_i (cache_rvalid_i),
    .cache_hit_i    (cache_hit_i),
    .cache_dirty_i  (cache_dirty_i),
    .cache_shared_i (cache_shared_i),
    .cache_line_i   (cache_line_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample mid-cycle, log lookup handshakes.
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      pend = 1'b0;
    end else begin
      if (cache_req_o) req_cycles++;
      if (cache_req_o && cache_gnt_i) begin
        pend = 1'b1;
        lookups++;
        look_addr.push_back(cache_addr_o);
      end
      if (cache_rvalid_i) rv_cyc = cyc;
      if (cd_valid_o) cd_seen = 1'b1;
    end
  end

  // Responder: one-cycle rvalid in the cycle after the grant.
  initial forever begin
    @(posedge clk);
    #1;
    cache_rvalid_i = 1'b0;
    if (pend && !rst_i) begin
      cache_rvalid_i = 1'b1;
      pend = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic send_ac(input logic [63:0] a, input logic [3:0] s);
    int n;
    ac_valid_i = 1'b1;
    ac_addr_i  = a;
    ac_snoop_i = s;
    ac_prot_i  = 3'b010;
    n = 0;
    @(negedge clk);
    while (!ac_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ac_ready_o) check("ac_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    ac_valid_i = 1'b0;
  endtask

  task automatic run_snoop(input string name, input logic [63:0] a, input logic [3:0] s,
                           input logic hit, input logic dirty, input logic shared,
                           input logic [127:0] line, input logic [63:0] exp_addr,
                           input logic [1:0] exp_op, input logic [4:0] exp_resp,
                           input bit do_lookup, input int nbeats,
                           input logic [63:0] b0, input logic [63:0] b1);
    int n, lk0, rq0, crc;
    cache_hit_i    = hit;
    cache_dirty_i  = dirty;
    cache_shared_i = shared;
    cache_line_i   = line;
    lk0 = lookups;
    rq0 = req_cycles;
    cd_seen = 1'b0;
    send_ac(a, s);
    check({name, "_req"}, cache_req_o, do_lookup);
    if (do_lookup) begin
      check({name, "_addr"}, cache_addr_o, exp_addr);
      check({name, "_op"}, cache_op_o, exp_op);
    end
    n = 0;
    @(negedge clk);
    while (!cr_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cr_valid_o) begin
      check({name, "_cr_timeout"}, 0, 1);
      tick();
      return;
    end
    check({name, "_resp"}, cr_resp_o, exp_resp);
    if (do_lookup) check({name, "_cr_lat"}, cyc - rv_cyc, 1);
    crc = cyc;
    if (nbeats == 0) begin
      tick();
      check({name, "_idle_after_cr"}, busy_o, 0);
      tick();
      tick();
      check({name, "_no_cd"}, cd_seen, 0);
    end else begin
      for (int b = 0; b < nbeats; b++) begin
        n = 0;
        @(negedge clk);
        while (!cd_valid_o && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (!cd_valid_o) begin
          check({name, "_cd_timeout"}, 0, 1);
          break;
        end
        if (b == 0) check({name, "_cd_lat"}, cyc - crc, 1);
        check($sformatf("%s_beat%0d", name, b), cd_data_o, (b == 0) ? b0 : b1);
        check($sformatf("%s_last%0d", name, b), cd_last_o, (b == nbeats - 1));
      end
      tick();
      check({name, "_idle_after_cd"}, busy_o, 0);
    end
    check({name, "_lookups"}, lookups - lk0, do_lookup ? 1 : 0);
    if (!do_lookup) check({name, "_req_cycles"}, req_cycles - rq0, 0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1; cache_gnt_i = 1'b1;
    cache_rvalid_i = 1'b0; cache_hit_i = 1'b0; cache_dirty_i = 1'b0;
    cache_shared_i = 1'b0; cache_line_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cr_valid", cr_valid_o, 0);
    check("rst_cd_valid", cd_valid_o, 0);
    check("rst_cd_last", cd_last_o, 0);
    check("rst_cache_req", cache_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_resp", cr_resp_o, 0);
    check("rst_ac_ready", ac_ready_o, 1);
    rst_i = 1'b0;
    tick();

    // ReadShared, hit dirty unique: WU=1 IS=1 PD=1 DT=1
    run_snoop("rd_shared", 64'h8000_1040, 4'b0001, 1, 1, 0,
              {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 64'h8000_1040,
              2'd1, 5'b11101, 1, 2, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111);
    // MakeInvalid, hit clean shared
    run_snoop("mk_inval", 64'h8000_3000, 4'b1101, 1, 0, 1, {2{64'h5555_5555_5555_5555}},
              64'h8000_3000, 2'd2, 5'b00000, 1, 0, '0, '0);
    // ReadUnique miss
    run_snoop("rd_uniq_miss", 64'h0000_0100, 4'b0111, 0, 0, 0, '1, 64'h0000_0100,
              2'd2, 5'b00000, 1, 0, '0, '0);
    // CleanShared, hit dirty shared, unaligned address: WU=0 IS=1 PD=1 DT=1
    run_snoop("cl_shared", 64'h8000_204C, 4'b1000, 1, 1, 1,
              {64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF}, 64'h8000_2040,
              2'd1, 5'b01101, 1, 2, 64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_CCCC_DDDD);
    // ReadOnce, hit clean unique: WU=1 IS=1 PD=0 DT=1
    run_snoop("rd_once", 64'h0000_0040, 4'b0000, 1, 0, 0,
              {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002}, 64'h0000_0040,
              2'd0, 5'b11001, 1, 2, 64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001);
    // CleanInvalid, hit dirty unique: WU=1 IS=0 PD=1 DT=1
    run_snoop("cl_inval", 64'h0000_0080, 4'b1001, 1, 1, 0,
              {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444}, 64'h0000_0080,
              2'd2, 5'b10101, 1, 2, 64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333);
    // Unsupported opcode
    run_snoop("unsupported", 64'h0000_00C0, 4'b1111, 1, 1, 0, '1, '0, 2'd0, 5'b00000,
              0, 0, '0, '0);

    // Back-to-back AC with grant held low: one in lookup, two buffered, then full.
    cache_gnt_i = 1'b0;
    cache_hit_i = 1'b0;
    look_addr.delete();
    n = lookups;
    send_ac(64'h0000_1000, 4'b0000);
    send_ac(64'h0000_2000, 4'b0000);
    send_ac(64'h0000_3000, 4'b0000);
    @(negedge clk);
    check("bp_ac_full", ac_ready_o, 0);
    check("bp_req_held", cache_req_o, 1);
    check("bp_addr_held", cache_addr_o, 64'h0000_1000);
    tick();
    cache_gnt_i = 1'b1;
    for (int i = 0; i < 200 && busy_o; i++) tick();
    check("bp_drained", busy_o, 0);
    check("bp_lookups", lookups - n, 3);
    if (look_addr.size() >= 3) begin
      check("bp_order0", look_addr[0], 64'h0000_1000);
      check("bp_order1", look_addr[1], 64'h0000_2000);
      check("bp_order2", look_addr[2], 64'h0000_3000);
    end

    // Reset during a stalled CD transfer.
    cd_ready_i     = 1'b0;
    cache_hit_i    = 1'b1;
    cache_dirty_i  = 1'b1;
    cache_shared_i = 1'b0;
    cache_line_i   = {64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    send_ac(64'h0000_4000, 4'b0001);
    n = 0;
    @(negedge clk);
    while (!cd_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) tick();
    check("rst_mid_cd_valid", cd_valid_o, 1);
    check("rst_mid_cd_data", cd_data_o, 64'h8888_8888_8888_8888);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_mid_cd_drop", cd_valid_o, 0);
    check("rst_mid_busy_drop", busy_o, 0);
    check("rst_mid_req_drop", cache_req_o, 0);
    tick();
    rst_i = 1'b0;
    cd_ready_i = 1'b1;
    tick();
    // ReadClean, hit clean shared: WU=0 IS=1 PD=0 DT=1
    run_snoop("post_rst", 64'h0000_5010, 4'b0010, 1, 0, 1,
              {64'h9999_0000_9999_0000, 64'h0000_6666_0000_6666}, 64'h0000_5010,
              2'd1, 5'b01001, 1, 2, 64'h0000_6666_0000_6666, 64'h9999_0000_9999_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
